// File: rtl/tone_scheduler_pkg.sv
// Shared definitions for the tone scheduler: state encoding, which doubles as the LED owner code.
package tone_scheduler_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_STREAM = 2'b01;
    localparam logic [1:0] ST_PIANO  = 2'b10;
    localparam logic [1:0] ST_GAP    = 2'b11;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_scheduler_cycle_timer.sv
// Loadable down-counter that saturates at zero; done_c flags an expired count.
module tone_scheduler_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done_c
);

    logic [W-1:0] value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign done_c = (value == '0);

endmodule

// File: rtl/tone_scheduler.sv
// Arbitrates the tone generator between the music streamer and the live piano path.
// Define TONE_SCHED_GAP_EN for full GAP_CYCLES articulation gaps; otherwise each gap is one cycle.
module tone_scheduler
    import tone_scheduler_pkg::*;
#(
    parameter int unsigned TONE_W          = 24,
    parameter int unsigned GAP_CYCLES      = 125_000,
    parameter int unsigned MIN_HOLD_CYCLES = 2_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TONE_W-1:0] stream_tone,
    input  logic              stream_valid,
    input  logic              piano_req,
    input  logic [TONE_W-1:0] piano_tone,
    output logic              piano_grant,
    output logic [TONE_W-1:0] tone,
    output logic              output_enable,
    output logic [1:0]        owner
);

    localparam int unsigned CNT_W     = $clog2(max_u(GAP_CYCLES, MIN_HOLD_CYCLES) + 1);
    localparam int unsigned HOLD_LOAD = (MIN_HOLD_CYCLES > 0) ? MIN_HOLD_CYCLES - 1 : 0;
`ifdef TONE_SCHED_GAP_EN
    localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
`else
    localparam int unsigned GAP_LOAD  = 0;
`endif

    logic [1:0]        state, state_d;
    logic [1:0]        target, target_d;
    logic [TONE_W-1:0] pend_tone, pend_d;
    logic [TONE_W-1:0] tone_d;
    logic              oe_d, grant_d;
    logic              gap_load, hold_load;
    logic              gap_done, hold_done;
    logic [1:0]        jump_tgt;
    logic [TONE_W-1:0] jump_tone;

    tone_scheduler_cycle_timer #(.W(CNT_W)) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (gap_load),
        .load_value (CNT_W'(GAP_LOAD)),
        .done_c     (gap_done)
    );

    tone_scheduler_cycle_timer #(.W(CNT_W)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .load_value (CNT_W'(HOLD_LOAD)),
        .done_c     (hold_done)
    );

    // Next-state: each state either requests a gap (jump_*) or moves directly; piano always wins.
    always_comb begin
        state_d   = state;
        target_d  = target;
        pend_d    = pend_tone;
        tone_d    = tone;
        gap_load  = 1'b0;
        hold_load = 1'b0;
        jump_tgt  = ST_STREAM;
        jump_tone = stream_tone;
        case (state)
            ST_IDLE: begin
                if (piano_req) begin
                    gap_load  = 1'b1;
                    jump_tgt  = ST_PIANO;
                    jump_tone = piano_tone;
                end else if (stream_valid) begin
                    gap_load = 1'b1;
                end
            end
            ST_STREAM: begin
                if (piano_req) begin
                    gap_load  = 1'b1;
                    jump_tgt  = ST_PIANO;
                    jump_tone = piano_tone;
                end else if (!stream_valid) begin
                    state_d = ST_IDLE;
                end else if (stream_tone != tone) begin
                    gap_load = 1'b1;
                end
            end
            ST_PIANO: begin
                if (piano_req) begin
                    if (piano_tone != tone) begin
                        gap_load  = 1'b1;
                        jump_tgt  = ST_PIANO;
                        jump_tone = piano_tone;
                    end
                end else if (hold_done) begin
                    if (stream_valid) gap_load = 1'b1;
                    else              state_d  = ST_IDLE;
                end
            end
            default: begin
                // A key press during a stream-bound gap steals it without restarting the count.
                if (target == ST_STREAM && piano_req) begin
                    target_d = ST_PIANO;
                    pend_d   = piano_tone;
                end
                if (gap_done) begin
                    state_d   = target_d;
                    tone_d    = pend_d;
                    hold_load = (target_d == ST_PIANO);
                end
            end
        endcase

        if (gap_load) begin
            state_d  = ST_GAP;
            target_d = jump_tgt;
            pend_d   = jump_tone;
        end

        case (state_d)
            ST_STREAM: oe_d = (tone_d != '0);
            ST_PIANO:  oe_d = 1'b1;
            default:   oe_d = 1'b0;
        endcase
        grant_d = (state_d == ST_PIANO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            target        <= ST_IDLE;
            pend_tone     <= '0;
            tone          <= '0;
            output_enable <= 1'b0;
            piano_grant   <= 1'b0;
        end else begin
            state         <= state_d;
            target        <= target_d;
            pend_tone     <= pend_d;
            tone          <= tone_d;
            output_enable <= oe_d;
            piano_grant   <= grant_d;
        end
    end

    assign owner = state;

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: directed scenarios plus random traffic against a cycle model.
module tb_tone_scheduler;

    localparam int unsigned TW = 24;
    localparam int unsigned G  = 4;
    localparam int unsigned H  = 10;
`ifdef TONE_SCHED_GAP_EN
    localparam int unsigned GEFF = G;
`else
    localparam int unsigned GEFF = 1;
`endif

    localparam logic [1:0] M_IDLE   = 2'b00;
    localparam logic [1:0] M_STREAM = 2'b01;
    localparam logic [1:0] M_PIANO  = 2'b10;
    localparam logic [1:0] M_GAP    = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] stream_tone = '0;
    logic          stream_valid = 1'b0;
    logic          piano_req = 1'b0;
    logic [TW-1:0] piano_tone = '0;
    logic          piano_grant;
    logic [TW-1:0] tone;
    logic          output_enable;
    logic [1:0]    owner;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [1:0]    m_mode, m_goal;
    logic [TW-1:0] m_tone, m_next;
    logic          m_oe, m_grant;
    int            m_gap_elapsed, m_hold_elapsed;

    tone_scheduler #(.TONE_W(TW), .GAP_CYCLES(G), .MIN_HOLD_CYCLES(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .stream_tone   (stream_tone),
        .stream_valid  (stream_valid),
        .piano_req     (piano_req),
        .piano_tone    (piano_tone),
        .piano_grant   (piano_grant),
        .tone          (tone),
        .output_enable (output_enable),
        .owner         (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_goal = M_IDLE; m_tone = '0; m_next = '0;
        m_oe = 1'b0; m_grant = 1'b0; m_gap_elapsed = 0; m_hold_elapsed = 0;
    endtask

    task automatic m_start_gap(input logic [1:0] goal, input logic [TW-1:0] t);
        m_mode = M_GAP; m_goal = goal; m_next = t; m_gap_elapsed = 0;
        m_oe = 1'b0; m_grant = 1'b0;
    endtask

    task automatic m_idle();
        m_mode = M_IDLE; m_oe = 1'b0; m_grant = 1'b0;
    endtask

    // One clock of the behavioural rules, using the inputs the DUT sees at the coming edge.
    task automatic model_step();
        case (m_mode)
            M_IDLE: begin
                if (piano_req)         m_start_gap(M_PIANO, piano_tone);
                else if (stream_valid) m_start_gap(M_STREAM, stream_tone);
            end
            M_STREAM: begin
                if (piano_req)                  m_start_gap(M_PIANO, piano_tone);
                else if (!stream_valid)         m_idle();
                else if (stream_tone != m_tone) m_start_gap(M_STREAM, stream_tone);
            end
            M_PIANO: begin
                m_hold_elapsed++;
                if (piano_req && piano_tone != m_tone) m_start_gap(M_PIANO, piano_tone);
                else if (!piano_req && m_hold_elapsed >= int'(H)) begin
                    if (stream_valid) m_start_gap(M_STREAM, stream_tone);
                    else              m_idle();
                end
            end
            default: begin
                if (m_goal == M_STREAM && piano_req) begin
                    m_goal = M_PIANO;
                    m_next = piano_tone;
                end
                m_gap_elapsed++;
                if (m_gap_elapsed >= int'(GEFF)) begin
                    m_mode = m_goal;
                    m_tone = m_next;
                    m_grant = (m_goal == M_PIANO);
                    m_oe = (m_goal == M_PIANO) ? 1'b1 : (m_next != '0);
                    m_hold_elapsed = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("tone", 32'(tone), 32'(m_tone));
        chk("output_enable", 32'(output_enable), 32'(m_oe));
        chk("owner", 32'(owner), 32'(m_mode));
        chk("piano_grant", 32'(piano_grant), 32'(m_grant));
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        m_reset();
        #1;
        chk("rst_tone", 32'(tone), 32'd0);
        chk("rst_oe", 32'(output_enable), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_grant", 32'(piano_grant), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Expect GEFF gap cycles, then the given steady outputs.
    task automatic gap_then(input string tag, input int exp_tone, input int exp_oe, input int exp_owner);
        for (int i = 0; i < int'(GEFF); i++) begin
            tick();
            chk({tag, "_gap_owner"}, 32'(owner), 32'd3);
        end
        tick();
        chk({tag, "_tone"}, 32'(tone), 32'(exp_tone));
        chk({tag, "_oe"}, 32'(output_enable), 32'(exp_oe));
        chk({tag, "_owner"}, 32'(owner), 32'(exp_owner));
    endtask

    initial begin
        int  cnt;
        bit  done;
        bit  saw_piano;

        #2;
        apply_reset();
        repeat (2) tick();

        // stream start, rest, resume
        stream_valid = 1'b1; stream_tone = 24'd1000;
        gap_then("start", 1000, 1, 1);
        stream_tone = 24'd0;
        gap_then("rest", 0, 0, 1);
        stream_tone = 24'd1000;
        gap_then("resume", 1000, 1, 1);

        // short piano tap preempts the stream and is held for the minimum length
        cnt = 0; done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            piano_req = (i < 2); piano_tone = 24'd500;
            tick();
            if (owner == M_PIANO && tone == 24'd500) cnt++;
            if (cnt > 0 && owner == M_STREAM && tone == 24'd1000) done = 1;
        end
        chk("tap_hold_cycles", 32'(cnt), 32'(H));
        chk("tap_back_to_stream", 32'(done), 32'd1);

        // piano request and stream change in the same cycle
        piano_req = 1'b1; piano_tone = 24'd500; stream_tone = 24'd2000;
        done = 0; saw_piano = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            piano_req = 1'b0;
            if (owner == M_PIANO && tone == 24'd500) saw_piano = 1;
            if (owner == M_STREAM && tone == 24'd2000) done = 1;
        end
        chk("tie_piano_first", 32'(saw_piano), 32'd1);
        chk("tie_stream_after", 32'(done), 32'd1);

        // piano note change mid-hold restarts the hold
        piano_req = 1'b1; piano_tone = 24'd500;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (owner == M_PIANO) done = 1;
        end
        chk("chg_piano_entered", 32'(done), 32'd1);
        repeat (3) tick();
        piano_tone = 24'd600;
        tick();
        chk("chg_gap_owner", 32'(owner), 32'd3);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (owner == M_PIANO && tone == 24'd600) done = 1;
        end
        chk("chg_new_note", 32'(done), 32'd1);
        piano_req = 1'b0;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (owner != M_PIANO) break;
            cnt++;
        end
        chk("chg_hold_cycles", 32'(cnt), 32'(H));
        repeat (int'(GEFF) + 2) tick();
        chk("chg_back_tone", 32'(tone), 32'd2000);

        // asynchronous reset while a stream note plays, then stay idle
        apply_reset();
        stream_valid = 1'b0; piano_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_owner", 32'(owner), 32'd0);
            chk("post_rst_oe", 32'(output_enable), 32'd0);
        end

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) stream_valid = ~stream_valid;
            if ($urandom_range(0, 11) == 0) stream_tone = 24'(1000 * $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  piano_req = ~piano_req;
            if ($urandom_range(0, 7) == 0)  piano_tone = 24'(500 + 100 * $urandom_range(0, 2));
            if ($urandom_range(0, 499) == 0) apply_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
